// File: rtl/bus_slice_pkg.sv
// Shared definitions for the bus slice gatherer: index-width derivation and
// the encoding of why a slice record was dropped.
package bus_slice_pkg;

   // Cause of the most recent dropped record, kept registered for debug.
   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_DUP    = 2'd1,
      ERR_RANGE  = 2'd2,
      ERR_BADBUS = 2'd3
   } err_cause_e;

   // Bits needed to index n items, never less than one.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_slice_lane.sv
// Per-bus gather state: collected bits, coverage mask and the "word complete"
// flag. A clear wins over a set; the top never issues both in one cycle.
module bus_slice_lane
   import bus_slice_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int BW    = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_i,
   input  logic [BW-1:0]    set_bit_i,
   input  logic             set_val_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] mask_o,
   output logic             pending_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             pending_q, pending_d;
   logic [WIDTH-1:0] onehot;

   // Next-state: write one bit and mark it covered, or release the lane.
   always_comb begin
      onehot    = WIDTH'(1) << set_bit_i;
      data_d    = data_q;
      mask_d    = mask_q;
      pending_d = pending_q;
      if (clr_i) begin
         mask_d    = '0;
         pending_d = 1'b0;
      end else if (set_i) begin
         data_d    = set_val_i ? (data_q | onehot) : (data_q & ~onehot);
         mask_d    = mask_q | onehot;
         pending_d = &(mask_q | onehot);
      end
   end

   // Lane state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         mask_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
      end
   end

   assign data_o    = data_q;
   assign mask_o    = mask_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/bus_slice_gather.sv
// Collects single-bit slice records into whole bus words and hands each
// completed word out through a one-entry valid/ready slot, lowest bus first.
module bus_slice_gather
   import bus_slice_pkg::*;
#(
   parameter int WIDTH   = 2,
   parameter int NUM_BUS = 2,
   parameter int BW      = idx_width(WIDTH),
   parameter int SW      = idx_width(NUM_BUS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SW-1:0]    in_bus,
   input  logic [BW-1:0]    in_bit,
   input  logic             in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SW-1:0]    out_bus,
   output logic [WIDTH-1:0] out_data,
   output logic             err
);

   logic [NUM_BUS-1:0] pend;
   logic [NUM_BUS-1:0] set_en;
   logic [NUM_BUS-1:0] clr_en;
   logic [WIDTH-1:0]   lane_data [NUM_BUS];
   logic [WIDTH-1:0]   lane_mask [NUM_BUS];

   logic               bus_ok, bit_ok, dup, pend_sel, accept;
   logic [WIDTH-1:0]   mask_sel;
   logic               any_pend, slot_free, load;
   logic [SW-1:0]      pick;
   logic [WIDTH-1:0]   pick_data;

   err_cause_e         err_q, err_d;
   logic               out_valid_q, out_valid_d;
   logic [SW-1:0]      out_bus_q, out_bus_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;

   for (genvar g = 0; g < NUM_BUS; g++) begin : g_lane
      bus_slice_lane #(.WIDTH(WIDTH), .BW(BW)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .set_i     (set_en[g]),
         .set_bit_i (in_bit),
         .set_val_i (in_value),
         .clr_i     (clr_en[g]),
         .data_o    (lane_data[g]),
         .mask_o    (lane_mask[g]),
         .pending_o (pend[g])
      );
   end

   // Input decode: in_ready depends only on the addressed bus, never on the output side.
   always_comb begin
      bus_ok   = (32'(in_bus) < NUM_BUS);
      bit_ok   = (32'(in_bit) < WIDTH);
      pend_sel = 1'b0;
      mask_sel = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         if (in_bus == SW'(b)) begin
            pend_sel = pend[b];
            mask_sel = lane_mask[b];
         end
      end
      dup      = |(mask_sel & (WIDTH'(1) << in_bit));
      in_ready = bus_ok & ~pend_sel;
      accept   = in_valid & in_ready;
      set_en   = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         set_en[b] = accept & bit_ok & ~dup & (in_bus == SW'(b));
      end
      err_d = ERR_NONE;
      if (in_valid & ~bus_ok)     err_d = ERR_BADBUS;
      else if (accept & ~bit_ok)  err_d = ERR_RANGE;
      else if (accept & dup)      err_d = ERR_DUP;
   end

   // Output slot: refill from the lowest-index complete bus when empty or draining.
   always_comb begin
      any_pend  = 1'b0;
      pick      = '0;
      pick_data = '0;
      for (int b = NUM_BUS - 1; b >= 0; b--) begin
         if (pend[b]) begin
            any_pend  = 1'b1;
            pick      = SW'(b);
            pick_data = lane_data[b];
         end
      end
      slot_free = ~out_valid_q | out_ready;
      load      = slot_free & any_pend;
      clr_en    = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         clr_en[b] = load & (pick == SW'(b));
      end
      out_valid_d = out_valid_q;
      out_bus_d   = out_bus_q;
      out_data_d  = out_data_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_bus_d   = pick;
         out_data_d  = pick_data;
      end else if (slot_free) begin
         out_valid_d = 1'b0;
      end
   end

   // Output slot and drop-cause registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_bus_q   <= '0;
         out_data_q  <= '0;
         err_q       <= ERR_NONE;
      end else begin
         out_valid_q <= out_valid_d;
         out_bus_q   <= out_bus_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bus   = out_bus_q;
   assign out_data  = out_data_q;
   assign err       = (err_q != ERR_NONE);

endmodule

// File: tb/tb_bus_slice_gather.sv
// Bench for bus_slice_gather: a 2-bit x 3-bus instance for the directed
// sequences and an 8-bit x 4-bus instance for shuffled interleaved traffic.
module tb_bus_slice_gather;

   localparam int WA = 2, NA = 3, BWA = 1, SWA = 2;
   localparam int WB = 8, NB = 4, BWB = 3, SWB = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic           in_valid_a, in_ready_a, in_value_a, out_valid_a, out_ready_a, err_a;
   logic [SWA-1:0] in_bus_a, out_bus_a;
   logic [BWA-1:0] in_bit_a;
   logic [WA-1:0]  out_data_a;

   logic           in_valid_b, in_ready_b, in_value_b, out_valid_b, out_ready_b, err_b;
   logic [SWB-1:0] in_bus_b, out_bus_b;
   logic [BWB-1:0] in_bit_b;
   logic [WB-1:0]  out_data_b;

   bus_slice_gather #(.WIDTH(WA), .NUM_BUS(NA)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bus(in_bus_a),
      .in_bit(in_bit_a), .in_value(in_value_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bus(out_bus_a),
      .out_data(out_data_a), .err(err_a)
   );

   bus_slice_gather #(.WIDTH(WB), .NUM_BUS(NB)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bus(in_bus_b),
      .in_bit(in_bit_b), .in_value(in_value_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bus(out_bus_b),
      .out_data(out_data_b), .err(err_b)
   );

   typedef struct {
      int bus;
      int data;
      int due;
   } exp_t;

   typedef struct {
      int bus;
      int bit_;
      bit val;
      bit push;
      int word;
      int gap;
   } vec_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   nchk = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   errs_a = 0;
   int   errs_b = 0;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every accepted output word is compared against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (err_a) errs_a++;
      if (err_b) errs_b++;
      if (out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL a_unexpected_word: got bus %0d data %0d, expected no word", out_bus_a, out_data_a);
         end else begin
            e = q_a.pop_front();
            chk("a_out_bus", int'(out_bus_a), e.bus);
            chk("a_out_data", int'(out_data_a), e.data);
            if (e.due >= 0) chk("a_latency", cyc, e.due);
         end
      end
      if (out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL b_unexpected_word: got bus %0d data %0d, expected no word", out_bus_b, out_data_b);
         end else begin
            e = q_b.pop_front();
            chk("b_out_bus", int'(out_bus_b), e.bus);
            chk("b_out_data", int'(out_data_b), e.data);
            if (e.due >= 0) chk("b_latency", cyc, e.due);
         end
      end
   end

   // Called at posedge+1; presents one record for exactly one cycle.
   task automatic send_a(input int b, input int bi, input bit v, input bit exp_rdy);
      in_valid_a = 1'b1;
      in_bus_a   = SWA'(b);
      in_bit_a   = BWA'(bi);
      in_value_a = v;
      @(negedge clk);
      chk("a_in_ready", int'(in_ready_a), int'(exp_rdy));
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[7];
      int   ord[32];
      int   cnt[NB];
      logic [WB-1:0] ref_w[NB];
      int   tmp, j, b, bi, t, errs0;

      tv[0] = '{bus:1, bit_:1, val:1'b1, push:1'b0, word:0, gap:0};
      tv[1] = '{bus:0, bit_:0, val:1'b0, push:1'b0, word:0, gap:0};
      tv[2] = '{bus:1, bit_:0, val:1'b0, push:1'b1, word:2, gap:0};
      tv[3] = '{bus:0, bit_:1, val:1'b1, push:1'b1, word:2, gap:2};
      tv[4] = '{bus:0, bit_:0, val:1'b0, push:1'b0, word:0, gap:0};
      tv[5] = '{bus:0, bit_:0, val:1'b1, push:1'b0, word:0, gap:0};
      tv[6] = '{bus:0, bit_:1, val:1'b1, push:1'b1, word:2, gap:3};

      rst_n = 1'b0;
      in_valid_a = 1'b0; in_bus_a = '0; in_bit_a = '0; in_value_a = 1'b0; out_ready_a = 1'b1;
      in_valid_b = 1'b0; in_bus_b = '0; in_bit_b = '0; in_value_b = 1'b0; out_ready_b = 1'b1;

      // Reset state
      idle(2);
      chk("rst_out_valid", int'(out_valid_a), 0);
      chk("rst_out_bus", int'(out_bus_a), 0);
      chk("rst_out_data", int'(out_data_a), 0);
      chk("rst_err", int'(err_a), 0);
      chk("rst_in_ready_bus0", int'(in_ready_a), 1);
      in_bus_a = 2'd3;
      #1;
      chk("rst_in_ready_bus3", int'(in_ready_a), 0);
      in_bus_a = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Table: basic gather, then duplicate assign dropped
      errs0 = errs_a;
      for (int i = 0; i < 7; i++) begin
         if (tv[i].push) q_a.push_back('{bus:tv[i].bus, data:tv[i].word, due:cyc + 2});
         send_a(tv[i].bus, tv[i].bit_, tv[i].val, 1'b1);
         if (tv[i].gap > 0) idle(tv[i].gap);
      end
      chk("dup_err_pulses", errs_a - errs0, 1);

      // Both buses complete while the consumer stalls
      out_ready_a = 1'b0;
      q_a.push_back('{bus:0, data:1, due:-1});
      send_a(0, 0, 1'b1, 1'b1);
      send_a(0, 1, 1'b0, 1'b1);
      q_a.push_back('{bus:1, data:3, due:-1});
      send_a(1, 0, 1'b1, 1'b1);
      send_a(1, 1, 1'b1, 1'b1);
      in_bus_a = 2'd0;
      @(negedge clk);
      chk("stall_bus0_ready", int'(in_ready_a), 1);
      @(posedge clk); #1;
      in_bus_a = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_out_valid", int'(out_valid_a), 1);
         chk("stall_out_bus", int'(out_bus_a), 0);
         chk("stall_out_data", int'(out_data_a), 1);
         chk("stall_bus1_ready", int'(in_ready_a), 0);
         @(posedge clk); #1;
      end
      out_ready_a = 1'b1;
      @(negedge clk);
      chk("release_bus", int'(out_bus_a), 0);
      chk("release_bus1_ready", int'(in_ready_a), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("next_valid", int'(out_valid_a), 1);
      chk("next_bus", int'(out_bus_a), 1);
      chk("next_data", int'(out_data_a), 3);
      chk("freed_bus1_ready", int'(in_ready_a), 1);
      @(posedge clk); #1;

      // Nonexistent bus: never ready, err one cycle later for each cycle
      errs0 = errs_a;
      in_valid_a = 1'b1; in_bus_a = 2'd3; in_bit_a = '0; in_value_a = 1'b1;
      @(negedge clk);
      chk("badbus_ready", int'(in_ready_a), 0);
      chk("badbus_err_c0", int'(err_a), 0);
      chk("badbus_out_valid", int'(out_valid_a), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("badbus_err_c1", int'(err_a), 1);
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("badbus_err_c2", int'(err_a), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("badbus_err_c3", int'(err_a), 0);
      chk("badbus_no_word", int'(out_valid_a), 0);
      @(posedge clk); #1;
      chk("badbus_err_pulses", errs_a - errs0, 2);

      // Reset mid-operation: half-filled bus0 and a held word are discarded
      out_ready_a = 1'b0;
      send_a(0, 0, 1'b1, 1'b1);
      send_a(1, 0, 1'b0, 1'b1);
      send_a(1, 1, 1'b1, 1'b1);
      idle(1);
      chk("pre_reset_valid", int'(out_valid_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", int'(out_valid_a), 0);
      chk("async_rst_data", int'(out_data_a), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready_a = 1'b1;
      idle(1);
      send_a(0, 1, 1'b1, 1'b1);
      q_a.push_back('{bus:0, data:2, due:cyc + 2});
      send_a(0, 0, 1'b0, 1'b1);
      send_a(1, 0, 1'b1, 1'b1);
      q_a.push_back('{bus:1, data:1, due:cyc + 2});
      send_a(1, 1, 1'b0, 1'b1);
      idle(4);

      // Wide buses, shuffled bit order, four buses interleaved
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 32; i++) ord[i] = i;
         for (int i = 31; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
         for (int k = 0; k < NB; k++) begin
            ref_w[k] = WB'($urandom);
            cnt[k] = 0;
         end
         for (int i = 0; i < 32; i++) begin
            b  = ord[i] / WB;
            bi = ord[i] % WB;
            cnt[b]++;
            if (cnt[b] == WB) q_b.push_back('{bus:b, data:int'(ref_w[b]), due:cyc + 2});
            in_valid_b = 1'b1;
            in_bus_b   = SWB'(b);
            in_bit_b   = BWB'(bi);
            in_value_b = ref_w[b][bi];
            @(negedge clk);
            chk("b_in_ready", int'(in_ready_b), 1);
            @(posedge clk); #1;
         end
         in_valid_b = 1'b0;
         idle(4);
      end

      t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < 50) begin
         @(posedge clk);
         t++;
      end
      chk("words_outstanding", q_a.size() + q_b.size(), 0);
      chk("a_err_total", errs_a, 3);
      chk("b_err_total", errs_b, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
